// File: rtl/jtag_system_top.sv
// JTAG TAP + RISC-V style DTM driving a minimal Debug Module and one modelled hart.
// TCK is oversampled on clk; every pin goes through a 2-flop synchroniser.
module jtag_system_top #(
  parameter logic [31:0] IDCODE = 32'h1DEAD3FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jtag_pin0_i,
  input  logic        jtag_pin1_i,
  output logic        jtag_pin1_o,
  output logic        jtag_pin1_oen,
  input  logic        jtag_pin2_i,
  output logic        jtag_pin3_o,
  output logic        jtag_pin3_oen,
  input  logic        jtag_trst_n_i,
  input  logic        mode_select,
  output logic [31:0] idcode,
  output logic        debug_req,
  output logic        hart_halted,
  output logic        active_mode
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  logic tck_p0, tck_p1, tck_p2;
  logic tms_p0, tms_p1, tdi_p0, tdi_p1, trst_p0, trst_p1;
  tap_state_t state;
  logic [7:0]  ir, ir_shift;
  logic [40:0] dr_shift;
  logic        tdo;
  logic        haltreq, dmactive, resumeack, resume_pend;
  logic [6:0]  last_addr;
  logic [31:0] last_rdata;
  logic        tck_rise, tck_fall, tap_rst, dmi_upd;

  assign jtag_pin1_o   = 1'b0;
  assign jtag_pin1_oen = 1'b1;
  assign jtag_pin3_o   = tdo;
  assign jtag_pin3_oen = !(state == SH_DR || state == SH_IR);
  assign idcode        = IDCODE;
  assign debug_req     = haltreq & dmactive;

  assign tck_rise = tck_p1 & ~tck_p2;
  assign tck_fall = ~tck_p1 & tck_p2;
  assign tap_rst  = !trst_p1 || (mode_select != active_mode);
  assign dmi_upd  = tck_rise && !tap_rst && tms_p1 && (ir == 8'h11) &&
                    (state == EX1_DR || state == EX2_DR);

  function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
    case (s)
      TLR:     next_state = tms ? TLR    : RTI;
      RTI:     next_state = tms ? SEL_DR : RTI;
      SEL_DR:  next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR:  next_state = tms ? EX1_DR : SH_DR;
      SH_DR:   next_state = tms ? EX1_DR : SH_DR;
      EX1_DR:  next_state = tms ? UPD_DR : PAU_DR;
      PAU_DR:  next_state = tms ? EX2_DR : PAU_DR;
      EX2_DR:  next_state = tms ? UPD_DR : SH_DR;
      UPD_DR:  next_state = tms ? SEL_DR : RTI;
      SEL_IR:  next_state = tms ? TLR    : CAP_IR;
      CAP_IR:  next_state = tms ? EX1_IR : SH_IR;
      SH_IR:   next_state = tms ? EX1_IR : SH_IR;
      EX1_IR:  next_state = tms ? UPD_IR : PAU_IR;
      PAU_IR:  next_state = tms ? EX2_IR : PAU_IR;
      EX2_IR:  next_state = tms ? UPD_IR : SH_IR;
      default: next_state = tms ? SEL_DR : RTI;
    endcase
  endfunction

  function automatic logic [31:0] dm_read(input logic [6:0] addr);
    dm_read = 32'h0;
    if (addr == 7'h10)
      dm_read = {haltreq, 30'b0, dmactive};
    else if (addr == 7'h11)
      dm_read = {14'b0, resumeack, resumeack, 4'b0, !hart_halted, !hart_halted,
                 hart_halted, hart_halted, 1'b1, 3'b0, 4'd2};
  endfunction

  // Pin synchronisers; tck_p2 is the previous synchronised TCK for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      {tck_p0, tck_p1, tck_p2} <= 3'b000;
      {tms_p0, tms_p1, tdi_p0, tdi_p1} <= 4'b0000;
      {trst_p0, trst_p1} <= 2'b11;
    end else begin
      {tck_p0, tck_p1, tck_p2} <= {jtag_pin0_i, tck_p0, tck_p1};
      {tms_p0, tms_p1} <= {jtag_pin1_i, tms_p0};
      {tdi_p0, tdi_p1} <= {jtag_pin2_i, tdi_p0};
      {trst_p0, trst_p1} <= {jtag_trst_n_i, trst_p0};
    end
  end

  // TAP controller, IR/DR shift paths and TDO
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TLR;
      ir          <= 8'h01;
      tdo         <= 1'b0;
      active_mode <= mode_select;
    end else begin
      active_mode <= mode_select;
      if (tap_rst) begin
        state <= TLR;
        ir    <= 8'h01;
      end else begin
        if (tck_rise) begin
          state <= next_state(state, tms_p1);
          case (state)
            TLR:    ir <= 8'h01;
            CAP_IR: ir_shift <= 8'h01;
            SH_IR:  ir_shift <= {tdi_p1, ir_shift[7:1]};
            EX1_IR, EX2_IR: if (tms_p1) ir <= ir_shift;
            CAP_DR:
              case (ir)
                8'h01:   dr_shift <= {9'b0, IDCODE};
                8'h10:   dr_shift <= {9'b0, 32'h00000071};
                8'h11:   dr_shift <= {last_addr, last_rdata, 2'b00};
                default: dr_shift <= 41'b0;
              endcase
            SH_DR:
              case (ir)
                8'h01, 8'h10: dr_shift <= {9'b0, tdi_p1, dr_shift[31:1]};
                8'h11:        dr_shift <= {tdi_p1, dr_shift[40:1]};
                default:      dr_shift <= {40'b0, tdi_p1};
              endcase
            default: ;
          endcase
        end
        if (tck_fall)
          tdo <= (state == SH_IR) ? ir_shift[0] : dr_shift[0];
      end
    end
  end

  // Debug Module registers and hart model
  always_ff @(posedge clk) begin
    if (rst) begin
      haltreq     <= 1'b0;
      dmactive    <= 1'b0;
      resumeack   <= 1'b0;
      resume_pend <= 1'b0;
      hart_halted <= 1'b0;
      last_addr   <= 7'h0;
      last_rdata  <= 32'h0;
    end else begin
      resume_pend <= 1'b0;
      if (resume_pend) begin
        hart_halted <= 1'b0;
        resumeack   <= 1'b1;
      end else if (debug_req && !hart_halted) begin
        hart_halted <= 1'b1;
        resumeack   <= 1'b0;
      end
      if (dmi_upd && dr_shift[1:0] == 2'd1) begin
        last_addr  <= dr_shift[40:34];
        last_rdata <= dm_read(dr_shift[40:34]);
      end else if (dmi_upd && dr_shift[1:0] == 2'd2) begin
        last_addr <= dr_shift[40:34];
        if (dr_shift[40:34] == 7'h10) begin
          dmactive <= dr_shift[2];
          haltreq  <= dr_shift[33] & dr_shift[2] & !(dr_shift[32] & hart_halted);
          if (!dr_shift[2])
            resumeack <= 1'b0;
          if (dr_shift[32] && dr_shift[2] && hart_halted)
            resume_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_system_top.sv
// Bench for jtag_system_top: directed JTAG/DMI scans plus randomized DMI traffic
// compared against a transaction-level model of the Debug Module and hart.
module tb_jtag_system_top;
  logic        clk = 1'b0;
  logic        rst, tck, tms, tdi, trst_n, mode_sel;
  logic        pin1_o, pin1_oen, tdo, tdo_oen, debug_req, hart_halted, active_mode;
  logic [31:0] idcode;
  int          errs = 0;
  int          checks = 0;

  // Reference model of DM-visible state
  logic        m_haltreq, m_dmactive, m_halted, m_resumeack;
  logic [6:0]  m_last_addr;
  logic [31:0] m_last_rdata;

  jtag_system_top dut (
    .clk(clk), .rst(rst),
    .jtag_pin0_i(tck), .jtag_pin1_i(tms), .jtag_pin1_o(pin1_o), .jtag_pin1_oen(pin1_oen),
    .jtag_pin2_i(tdi), .jtag_pin3_o(tdo), .jtag_pin3_oen(tdo_oen),
    .jtag_trst_n_i(trst_n), .mode_select(mode_sel), .idcode(idcode),
    .debug_req(debug_req), .hart_halted(hart_halted), .active_mode(active_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One TCK period; o is the TDO value seen before this period's rising edge
  task automatic tck_cycle(input logic m, input logic d, output logic o);
    o = tdo;
    tms = m;
    tdi = d;
    clks(4);
    tck = 1'b1;
    clks(5);
    tck = 1'b0;
    clks(5);
  endtask

  task automatic tap_reset();
    logic o;
    repeat (5) tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
  endtask

  task automatic scan_ir(input logic [7:0] v, output logic [7:0] cap);
    logic o;
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    for (int i = 0; i < 8; i++) begin
      tck_cycle(i == 7, v[i], o);
      cap[i] = o;
    end
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
  endtask

  task automatic scan_dr(input int n, input logic [40:0] v, output logic [40:0] cap);
    logic o;
    cap = '0;
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, v[i], o);
      cap[i] = o;
    end
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
  endtask

  function automatic logic [31:0] m_read(input logic [6:0] a);
    logic [31:0] s;
    s = 32'h0;
    if (a == 7'h10) begin
      s[31] = m_haltreq;
      s[0]  = m_dmactive;
    end else if (a == 7'h11) begin
      s[3:0] = 4'd2;
      s[7]   = 1'b1;
      s[8]   = m_halted;
      s[9]   = m_halted;
      s[10]  = !m_halted;
      s[11]  = !m_halted;
      s[16]  = m_resumeack;
      s[17]  = m_resumeack;
    end
    return s;
  endfunction

  task automatic m_apply(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
    if (op == 2'd1) begin
      m_last_addr  = a;
      m_last_rdata = m_read(a);
    end else if (op == 2'd2) begin
      m_last_addr = a;
      if (a == 7'h10) begin
        if (!d[0]) begin
          m_haltreq   = 1'b0;
          m_dmactive  = 1'b0;
          m_resumeack = 1'b0;
        end else begin
          m_dmactive = 1'b1;
          m_haltreq  = d[31];
          if (d[30] && m_halted) begin
            m_haltreq   = 1'b0;
            m_halted    = 1'b0;
            m_resumeack = 1'b1;
          end
        end
      end
    end
    if (m_haltreq && m_dmactive && !m_halted) begin
      m_halted    = 1'b1;
      m_resumeack = 1'b0;
    end
  endtask

  // One DMI scan: checks the captured {addr,data} then advances the model
  task automatic dmi(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                     output logic [40:0] cap);
    scan_dr(41, {a, d, op}, cap);
    check("dmi_capture", 64'(cap), 64'({m_last_addr, m_last_rdata, 2'b00}));
    m_apply(op, a, d);
    clks(3);
    check("hart_halted", 64'(hart_halted), 64'(m_halted));
  endtask

  initial begin
    logic [40:0] cap;
    logic [7:0]  icap;
    logic [7:0]  bv;
    logic        o;
    rst = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0; trst_n = 1'b1; mode_sel = 1'b0;
    {m_haltreq, m_dmactive, m_halted, m_resumeack} = 4'b0;
    m_last_addr = 7'h0;
    m_last_rdata = 32'h0;
    clks(4);
    rst = 1'b0;
    clks(2);
    check("rst_tdo", 64'(tdo), 64'(0));
    check("rst_tdo_oen", 64'(tdo_oen), 64'(1));
    check("rst_debug_req", 64'(debug_req), 64'(0));
    check("rst_halted", 64'(hart_halted), 64'(0));
    check("rst_active_mode", 64'(active_mode), 64'(0));
    check("pin1", 64'({pin1_o, pin1_oen}), 64'(2'b01));
    check("idcode_port", 64'(idcode), 64'(32'h1DEAD3FF));

    // IDCODE selected after reset
    tap_reset();
    scan_dr(32, 41'h0, cap);
    check("idcode_scan", 64'(cap), 64'(32'h1DEAD3FF));

    // BYPASS (explicit and undecoded IR) and DTMCS
    bv = 8'($urandom);
    scan_ir(8'hFF, icap);
    check("ir_capture", 64'(icap), 64'(8'h01));
    scan_dr(8, {33'h0, bv}, cap);
    check("bypass", 64'(cap), 64'({bv[6:0], 1'b0}));
    scan_ir(8'h42, icap);
    scan_dr(8, {33'h0, ~bv}, cap);
    check("bypass_undecoded", 64'(cap), 64'({~bv[6:0], 1'b0}));
    scan_ir(8'h10, icap);
    scan_dr(32, 41'h0, cap);
    check("dtmcs", 64'(cap), 64'(32'h00000071));

    // DMSTATUS read, running hart
    scan_ir(8'h11, icap);
    dmi(2'd1, 7'h11, 32'h0, cap);
    dmi(2'd0, 7'h00, 32'h0, cap);
    check("dmstatus_run", 64'(cap[33:2]), 64'(32'h00000C82));

    // Halt request with debug_req -> hart_halted latency
    fork
      dmi(2'd2, 7'h10, 32'h80000001, cap);
      begin
        int k = 0;
        while (!debug_req && k < 3000) begin
          @(posedge clk); #1;
          k++;
        end
        check("debug_req_seen", 64'(debug_req), 64'(1));
        check("halt_lat0", 64'(hart_halted), 64'(0));
        @(posedge clk); #1;
        check("halt_lat1", 64'(hart_halted), 64'(1));
      end
    join
    dmi(2'd1, 7'h11, 32'h0, cap);
    dmi(2'd0, 7'h00, 32'h0, cap);
    check("dmstatus_halt", 64'(cap[33:2]), 64'(32'h00000382));

    // Resume
    dmi(2'd2, 7'h10, 32'h40000001, cap);
    check("resumed", 64'(hart_halted), 64'(0));
    check("debug_req_off", 64'(debug_req), 64'(0));
    dmi(2'd1, 7'h11, 32'h0, cap);
    dmi(2'd0, 7'h00, 32'h0, cap);
    check("dmstatus_resume", 64'(cap[33:2]), 64'(32'h00030C82));

    // Randomized DMI traffic against the model
    for (int n = 0; n < 24; n++) begin
      logic [31:0] d;
      int r;
      r = int'($urandom_range(0, 6));
      d = $urandom;
      case (r)
        0: dmi(2'd2, 7'h10, {d[31:30], 29'h0, d[0] | d[1]}, cap);
        1: dmi(2'd2, 7'($urandom), d, cap);
        2: dmi(2'd1, 7'h10, d, cap);
        3: dmi(2'd1, 7'h11, d, cap);
        4: dmi(2'd1, 7'($urandom), d, cap);
        5: dmi(2'd3, 7'h10, d, cap);
        default: dmi(2'd0, 7'($urandom), d, cap);
      endcase
      check("debug_req_rand", 64'(debug_req), 64'(m_haltreq & m_dmactive));
    end

    // Mode switch in the middle of a DMI shift
    dmi(2'd2, 7'h10, 32'h80000001, cap);
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    repeat (5) tck_cycle(1'b0, 1'b1, o);
    check("mid_shift_oen", 64'(tdo_oen), 64'(0));
    mode_sel = 1'b1;
    clks(3);
    check("mode_follow", 64'(active_mode), 64'(1));
    check("mode_tap_reset", 64'(tdo_oen), 64'(1));
    tck_cycle(1'b0, 1'b0, o);
    scan_dr(32, 41'h0, cap);
    check("mode_idcode", 64'(cap), 64'(32'h1DEAD3FF));
    scan_ir(8'h11, icap);
    dmi(2'd0, 7'h00, 32'h0, cap);

    // Rapid mode toggles: DM and hart state survive
    for (int t = 0; t < 5; t++) begin
      mode_sel = ~mode_sel;
      clks(3);
      check("toggle_mode", 64'(active_mode), 64'(mode_sel));
      tck_cycle(1'b0, 1'b0, o);
      scan_dr(32, 41'h0, cap);
      check("toggle_idcode", 64'(cap), 64'(32'h1DEAD3FF));
      check("toggle_halted", 64'(hart_halted), 64'(m_halted));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
